// File: rtl/femto_pkg.sv
// femtoRV32 shared types and constants.
// Used by decode, the decode/execute register and execute.
package femto_pkg;

    localparam int REG_AD_W = 5;
    localparam logic [REG_AD_W-1:0] X0 = 5'd0;
    localparam int CTRL_W = 8;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic reg_write;
    } ex_ctrl_t;

endpackage

// File: rtl/operand_bypass.sv
// Source operand select: x0 forced to zero, then same-cycle
// writeback bypass, then the register file read value.
module operand_bypass
    import femto_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [REG_AD_W-1:0] rs,
    input  logic [n-1:0]        rf_data,
    input  logic                wb_we,
    input  logic [REG_AD_W-1:0] wb_ad,
    input  logic [n-1:0]        wb_data,
    output logic [n-1:0]        op
);

    // Priority select; x0 wins because the RF does not protect it.
    always_comb begin
        op = rf_data;
        if (rs == X0)
            op = '0;
        else if (wb_we && wb_ad == rs)
            op = wb_data;
    end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with valid/ready handshake,
// wb bypass, held-operand refresh and load-use bubble insertion.
module decode_execute_reg #(
    parameter int n      = 32,
    parameter int CTRL_W = femto_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [n-1:0]      in_pc,
    input  logic [n-1:0]      in_imm,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_mem_read,
    input  logic              in_reg_write,
    input  logic [n-1:0]      rf_rd1,
    input  logic [n-1:0]      rf_rd2,
    input  logic              wb_we,
    input  logic [4:0]        wb_ad,
    input  logic [n-1:0]      wb_data,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [n-1:0]      out_pc,
    output logic [n-1:0]      out_imm,
    output logic [n-1:0]      out_op1,
    output logic [n-1:0]      out_op2,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_mem_read,
    output logic              out_reg_write,
    output logic [31:0]       stall_count
);
    import femto_pkg::*;

    logic              valid_q, valid_d;
    logic [n-1:0]      pc_q, pc_d, imm_q, imm_d;
    logic [n-1:0]      op1_q, op1_d, op2_q, op2_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    ex_ctrl_t          exc_q, exc_d;
    logic [31:0]       cnt_q, cnt_d;

    logic [n-1:0] sel1, sel2;
    logic         hazard, xfer;

    operand_bypass #(.n(n)) u_bp1 (
        .rs      (in_rs1),
        .rf_data (rf_rd1),
        .wb_we   (wb_we),
        .wb_ad   (wb_ad),
        .wb_data (wb_data),
        .op      (sel1)
    );

    operand_bypass #(.n(n)) u_bp2 (
        .rs      (in_rs2),
        .rf_data (rf_rd2),
        .wb_we   (wb_we),
        .wb_ad   (wb_ad),
        .wb_data (wb_data),
        .op      (sel2)
    );

    // Load-use hazard detect and accept handshake.
    always_comb begin
        hazard = valid_q && exc_q.mem_read && rd_q != X0 &&
                 in_valid && (rd_q == in_rs1 || rd_q == in_rs2);
        in_ready = !rst && !flush && !hazard &&
                   (!valid_q || out_ready);
        xfer = in_valid && in_ready;
    end

    // Next state: flush, then load, then drain, then hold+refresh.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        exc_d   = exc_q;
        cnt_d   = cnt_q;
        if (hazard && out_ready && cnt_q != 32'hFFFF_FFFF)
            cnt_d = cnt_q + 32'd1;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            imm_d   = in_imm;
            op1_d   = sel1;
            op2_d   = sel2;
            rs1_d   = in_rs1;
            rs2_d   = in_rs2;
            rd_d    = in_rd;
            ctrl_d  = in_ctrl;
            exc_d   = '{mem_read: in_mem_read,
                        reg_write: in_reg_write};
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (wb_we && wb_ad != X0 && wb_ad == rs1_q)
                op1_d = wb_data;
            if (wb_we && wb_ad != X0 && wb_ad == rs2_q)
                op2_d = wb_data;
        end
    end

    // Register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            exc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_imm       = imm_q;
    assign out_op1       = op1_q;
    assign out_op2       = op2_q;
    assign out_rs1       = rs1_q;
    assign out_rs2       = rs2_q;
    assign out_rd        = rd_q;
    assign out_ctrl      = ctrl_q;
    assign out_mem_read  = exc_q.mem_read;
    assign out_reg_write = exc_q.reg_write;
    assign stall_count   = cnt_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Self-checking bench for decode_execute_reg: directed steps,
// then randomized traffic against a transaction-level model.
module tb_decode_execute_reg;

    localparam int N  = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready;
    logic [N-1:0]  in_pc, in_imm, rf_rd1, rf_rd2, wb_data;
    logic [4:0]    in_rs1, in_rs2, in_rd, wb_ad;
    logic [CW-1:0] in_ctrl;
    logic          in_mem_read, in_reg_write, wb_we, flush, out_ready;
    logic          out_valid, out_mem_read, out_reg_write;
    logic [N-1:0]  out_pc, out_imm, out_op1, out_op2;
    logic [4:0]    out_rs1, out_rs2, out_rd;
    logic [CW-1:0] out_ctrl;
    logic [31:0]   stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_execute_reg #(.n(N), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_ctrl(in_ctrl),
        .in_mem_read(in_mem_read), .in_reg_write(in_reg_write),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_ad(wb_ad), .wb_data(wb_data),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_imm(out_imm),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_ctrl(out_ctrl),
        .out_mem_read(out_mem_read), .out_reg_write(out_reg_write),
        .stall_count(stall_count)
    );

    // Expected contents of the register as seen by execute.
    typedef struct {
        logic          v;
        logic [N-1:0]  pc, imm, op1, op2;
        logic [4:0]    rs1, rs2, rd;
        logic [CW-1:0] ctrl;
        logic          mr, rw;
        logic [31:0]   cnt;
    } slot_t;

    slot_t m, nx;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] pick(input logic [4:0] rs,
                                          input logic [N-1:0] rf);
        if (rs == 0) return '0;
        if (wb_we && wb_ad == rs) return wb_data;
        return rf;
    endfunction

    task automatic idle();
        in_valid = 0; in_pc = 0; in_imm = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_ctrl = 0;
        in_mem_read = 0; in_reg_write = 0;
        rf_rd1 = 0; rf_rd2 = 0;
        wb_we = 0; wb_ad = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic instr(input logic [N-1:0] pc, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input logic mr);
        in_valid = 1; in_pc = pc; in_imm = pc ^ 32'h5A5A_0000;
        in_rs1 = r1; in_rs2 = r2; in_rd = rd;
        in_ctrl = pc[7:0] ^ 8'h3C;
        in_mem_read = mr; in_reg_write = 1;
        rf_rd1 = 32'h1000_0000 | pc; rf_rd2 = 32'h2000_0000 | pc;
    endtask

    // One clock: check handshake, advance model, check outputs.
    task automatic tick();
        logic hz, rdy;
        #1;
        hz = m.v && m.mr && m.rd != 0 && in_valid &&
             (m.rd == in_rs1 || m.rd == in_rs2);
        rdy = !rst && !flush && !hz && (!m.v || out_ready);
        chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        nx = m;
        if (rst) begin
            nx = '{default: '0};
        end else begin
            if (hz && out_ready && m.cnt != 32'hFFFF_FFFF)
                nx.cnt = m.cnt + 1;
            if (flush) nx.v = 0;
            else if (in_valid && rdy) begin
                nx.v = 1; nx.pc = in_pc; nx.imm = in_imm;
                nx.op1 = pick(in_rs1, rf_rd1);
                nx.op2 = pick(in_rs2, rf_rd2);
                nx.rs1 = in_rs1; nx.rs2 = in_rs2; nx.rd = in_rd;
                nx.ctrl = in_ctrl; nx.mr = in_mem_read;
                nx.rw = in_reg_write;
            end else if (m.v && out_ready) nx.v = 0;
            else if (m.v && wb_we && wb_ad != 0) begin
                if (wb_ad == m.rs1) nx.op1 = wb_data;
                if (wb_ad == m.rs2) nx.op2 = wb_data;
            end
        end
        @(posedge clk);
        #1;
        m = nx;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m.v});
        chk("stall_count", {32'd0, stall_count}, {32'd0, m.cnt});
        if (m.v) begin
            chk("out_pc", {32'd0, out_pc}, {32'd0, m.pc});
            chk("out_imm", {32'd0, out_imm}, {32'd0, m.imm});
            chk("out_op1", {32'd0, out_op1}, {32'd0, m.op1});
            chk("out_op2", {32'd0, out_op2}, {32'd0, m.op2});
            chk("out_regs", {49'd0, out_rs1, out_rs2, out_rd},
                {49'd0, m.rs1, m.rs2, m.rd});
            chk("out_ctrl", {54'd0, out_ctrl, out_mem_read,
                out_reg_write}, {54'd0, m.ctrl, m.mr, m.rw});
        end
    endtask

    initial begin
        m = '{default: '0};
        idle();
        rst = 1;
        tick();
        tick();
        chk("rst_data", {out_op1, out_pc}, 64'd0);
        chk("rst_flags", {61'd0, out_valid, out_mem_read,
            out_reg_write}, 64'd0);
        rst = 0;

        // Streaming: four back-to-back ALU ops.
        for (int i = 0; i < 4; i++) begin
            instr(32'h100 + 4 * i, 5'(i + 1), 5'(i + 9), 5'(20 + i), 0);
            tick();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_pc", {32'd0, out_pc}, 64'h100 + 4 * i);
        end
        idle();
        tick();

        // Writeback bypass, then x0 forced to zero.
        instr(32'h200, 5, 6, 10, 0);
        rf_rd1 = 32'h11; wb_we = 1; wb_ad = 5; wb_data = 32'hAB;
        tick();
        chk("wb_bypass", {32'd0, out_op1}, 64'hAB);
        instr(32'h204, 0, 6, 10, 0);
        rf_rd1 = 32'h11; wb_we = 1; wb_ad = 0; wb_data = 32'hAB;
        tick();
        chk("x0_zero", {32'd0, out_op1}, 64'd0);
        idle();
        tick();

        // Load-use: one bubble, then the dependent op transfers.
        instr(32'h300, 1, 2, 7, 1);
        tick();
        instr(32'h304, 3, 7, 8, 0);
        #1;
        chk("lu_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("lu_bubble", {63'd0, out_valid}, 64'd0);
        chk("lu_stall", {32'd0, stall_count}, 64'd1);
        tick();
        chk("lu_xfer", {59'd0, out_valid, out_rs2}, {59'd0, 1'b1, 5'd7});
        idle();
        tick();

        // Hold refresh of op2 from a writeback to x3.
        instr(32'h400, 4, 3, 9, 0);
        tick();
        idle(); out_ready = 0;
        wb_we = 1; wb_ad = 3; wb_data = 32'h55;
        tick();
        chk("refresh", {32'd0, out_op2}, 64'h55);
        wb_we = 0;
        tick();
        out_ready = 1;
        #1;
        chk("emit", {31'd0, out_valid, out_op2}, {31'd0, 1'b1, 32'h55});
        tick();

        // Flush while holding with a new instruction offered.
        instr(32'h500, 1, 2, 3, 0);
        tick();
        instr(32'h504, 4, 5, 6, 0);
        out_ready = 0; flush = 1;
        #1;
        chk("flush_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        idle();
        tick();
        chk("flush_nocap", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of a hold.
        instr(32'h600, 2, 0, 4, 0);
        tick();
        idle(); out_ready = 0;
        tick();
        rst = 1;
        tick();
        chk("rst_hold", {31'd0, out_valid, out_op1}, 64'd0);
        chk("rst_cnt", {32'd0, stall_count}, 64'd0);
        rst = 0;

        // Randomized traffic with a narrow register range.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc = $urandom; in_imm = $urandom;
            in_rs1 = 5'($urandom_range(0, 7));
            in_rs2 = 5'($urandom_range(0, 7));
            in_rd = 5'($urandom_range(0, 7));
            in_ctrl = 8'($urandom);
            in_mem_read = ($urandom_range(0, 2) == 0);
            in_reg_write = 1'($urandom);
            rf_rd1 = $urandom; rf_rd2 = $urandom;
            wb_we = 1'($urandom);
            wb_ad = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_execute_reg.md
# decode_execute_reg

Pipeline register between decode and execute in the femtoRV32 core. Captures the two register-file read operands, immediate, PC and control for one instruction, and presents them to the execute stage under a valid/ready handshake. Also handles three operand hazards: it bypasses a same-cycle writeback, refreshes held operands, and inserts one bubble for a load-use hazard.

## Interface
Parameters:
- n, 32, datapath width
- CTRL_W, 8, width of opaque execute control bundle

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  register accepts this cycle
- in_pc, in_imm  in  n  PC and decoded immediate
- in_rs1, in_rs2  in  5  source register addresses (also drive register file read_1/read_2)
- in_rd  in  5  destination register
- in_ctrl  in  CTRL_W  execute control bundle
- in_mem_read, in_reg_write  in  1  instruction is a load / writes rd
- rf_rd1, rf_rd2  in  n  register file read1_out/read2_out
- wb_we  in  1, wb_ad  in  5, wb_data  in  n  writeback port; same signals as register file wr_enable/write_ad/data
- flush  in  1  kill held instruction (branch redirect)
- out_ready  in  1  execute accepts
- out_valid  out  1; out_pc, out_imm, out_op1, out_op2  out  n; out_rs1, out_rs2, out_rd  out  5; out_ctrl  out  CTRL_W; out_mem_read, out_reg_write  out  1
- stall_count  out  32  saturating count of load-use bubble cycles

## Operation
- Operand select for each source s, evaluated in priority order:
  - If in_rs_s == 0, the operand is 0. The register file does not guard x0 against writes, so this block must force it.
  - Else if wb_we && wb_ad == in_rs_s, the operand is wb_data.
  - Else the operand is rf_rd_s.
- hazard = out_valid && out_mem_read && out_rd != 0 && in_valid && (out_rd == in_rs1 || out_rd == in_rs2).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Transfer occurs on in_valid && in_ready. Next cycle: all out_* fields are loaded and out_valid = 1.
- Drain: out_valid && out_ready with no transfer gives out_valid = 0 next cycle. This includes the hazard cycle, which becomes the bubble.
- Hold: out_valid && !out_ready. All fields are kept, except operand refresh:
  - If wb_we && wb_ad != 0 && wb_ad == out_rs1, out_op1 <= wb_data.
  - Same rule for out_rs2 and out_op2.
- Flush: out_valid <= 0 next cycle regardless of out_ready or in_valid. Flush has priority over hold, load and hazard. Data fields are don't-care.
- stall_count increments on each cycle where hazard && out_ready and saturates at 0xFFFFFFFF.
- Reset: out_valid = 0, all data outputs = 0, stall_count = 0. in_ready is 0 while rst = 1. Reset mid-hold discards the held instruction.

## Timing
- Latency: 1 cycle from transfer to out_valid.
- Throughput: 1 instruction per cycle with out_ready held high and no hazards.
- Load-use: exactly one bubble cycle. The dependent instruction transfers on the cycle after the load leaves; from there, execute-side forwarding owns the hazard.
- in_ready is combinational from out_valid, out_ready, flush and hazard. It has no dependency on in_ready itself.
- wb bypass is same-cycle. The register file writes at the same posedge, so without the bypass its read would return stale data.

## Structure
- Shared package, femto_pkg:
  - REG_AD_W = 5
  - X0 = 5'd0
  - CTRL_W
  - a control-bundle struct/typedef used by decode and execute
- Sub-module operand_bypass: combinational, instantiated twice (op1, op2). Implements the x0 / wb / rf select; the top level uses the same rule for hold refresh.
- Top level: hazard detect, handshake, register bank, counter.

## Test plan
- Streaming: 4 back-to-back ALU ops with out_ready = 1 -> out_valid high 4 consecutive cycles, one cycle after each transfer; fields match inputs.
- WB bypass: in_rs1 = 5, rf_rd1 = 0x11, wb_we = 1, wb_ad = 5, wb_data = 0xAB -> out_op1 = 0xAB. Repeat with in_rs1 = 0, wb_ad = 0 -> out_op1 = 0.
- Load-use: load with rd = 7 in output, next instruction has rs2 = 7 -> in_ready = 0 for 1 cycle, one bubble (out_valid = 0), stall_count = 1, then the instruction transfers.
- Hold refresh: out_ready = 0 with out_rs2 = 3 held; wb writes x3 = 0x55 -> out_op2 = 0x55 while held, emitted when out_ready rises.
- Flush while held and while in_valid = 1 -> in_ready = 0, out_valid = 0 next cycle, and the incoming instruction is not captured.
- Reset asserted mid-hold -> next cycle out_valid = 0, out_op1 = 0, stall_count = 0.
